// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
//   Shared definitions for the BIST session controller:
//   - state_t            : session FSM state encoding
//   - MISR_POLY_DEFAULT  : default MISR feedback taps for an 8-bit datapath
// -----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEED = 3'd1,
    ST_RUN  = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] MISR_POLY_DEFAULT = 8'hB8;

endpackage

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
//   Multiple-input signature register, right-shift Galois form using the same
//   tap convention as the pattern LFSR. Bit 0 is the feedback bit; it always
//   re-enters at the top and is XORed into every lower bit whose tap is set.
// Ports
//   clk     in   1   clock
//   rst     in   1   synchronous active-high reset (clears the signature)
//   i_clr   in   1   synchronous clear at session start
//   i_en    in   1   absorb i_resp this cycle
//   i_resp  in   n   response word to compact
//   o_sig   out  n   current MISR contents
// -----------------------------------------------------------------------------
module bist_misr
  import bist_pkg::*;
#(
  parameter int             n         = 8,
  parameter logic [n-1:0]   MISR_POLY = MISR_POLY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [n-1:0] i_resp,
  output logic [n-1:0] o_sig
);

  logic [n-1:0] r_misr;
  logic [n-1:0] w_misr_next;

  // The top bit takes the feedback bit directly; MISR_POLY[n-1] is implied.
  assign w_misr_next[n-1] = r_misr[0] ^ i_resp[n-1];

  genvar gi;
  generate
    for (gi = 0; gi < n - 1; gi++) begin : g_misr_bit
      assign w_misr_next[gi] = (r_misr[0] & MISR_POLY[gi]) ^ r_misr[gi+1] ^ i_resp[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_misr <= '0;
    end else if (i_en) begin
      r_misr <= w_misr_next;
    end
  end

  assign o_sig = r_misr;

endmodule

// File: rtl/bist_ctrl.sv
// -----------------------------------------------------------------------------
// bist_ctrl
//   Runs one BIST session: loads the external LFSR, steps it NUM_PATTERNS
//   times while compacting CUT responses into an internal MISR, then compares
//   the signature with the golden value captured at start.
// Ports
//   clk            in   1   clock
//   rst            in   1   synchronous active-high reset
//   i_start        in   1   begin session (honoured only in IDLE)
//   i_abort        in   1   cancel a running session
//   i_seed         in   n   LFSR seed, captured on accepted start
//   i_poly         in   n   LFSR polynomial, captured on accepted start
//   i_golden_sig   in   n   expected signature, captured on accepted start
//   i_cut_resp     in   n   CUT response to the current pattern
//   o_lfsr_rst     out  1   LFSR load pulse
//   o_lfsr_en      out  1   LFSR step enable
//   o_lfsr_seed    out  n   captured seed
//   o_lfsr_poly    out  n   captured polynomial
//   o_bist_mode    out  1   CUT input mux selects the LFSR
//   o_busy         out  1   session in progress
//   o_done         out  1   one-cycle result-valid pulse
//   o_pass         out  1   signature matched golden
//   o_err          out  1   zero seed rejected
//   o_signature    out  n   final MISR value
// -----------------------------------------------------------------------------
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int           n            = 8,
  parameter int           NUM_PATTERNS = 255,
  parameter int           CNT_W        = 8,
  parameter logic [n-1:0] MISR_POLY    = MISR_POLY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [n-1:0] i_seed,
  input  logic [n-1:0] i_poly,
  input  logic [n-1:0] i_golden_sig,
  input  logic [n-1:0] i_cut_resp,
  output logic         o_lfsr_rst,
  output logic         o_lfsr_en,
  output logic [n-1:0] o_lfsr_seed,
  output logic [n-1:0] o_lfsr_poly,
  output logic         o_bist_mode,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_pass,
  output logic         o_err,
  output logic [n-1:0] o_signature
);

  state_t       r_state;
  state_t       w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [n-1:0]     r_seed;
  logic [n-1:0]     r_poly;
  logic [n-1:0]     r_golden;
  logic [n-1:0]     r_signature;
  logic             r_pass;
  logic             r_err;

  logic             w_start_ok;
  logic             w_abort_act;
  logic             w_last;
  logic             w_seed_zero;

  logic             w_lfsr_rst;
  logic             w_lfsr_en;
  logic             w_bist_mode;
  logic             w_busy;
  logic             w_done;
  logic             w_misr_clr;
  logic             w_misr_en;
  logic [n-1:0]     w_misr_sig;

  // Abort beats a simultaneous start in IDLE.
  assign w_start_ok  = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_abort_act = i_abort && (r_state inside {ST_SEED, ST_RUN, ST_CMP});
  assign w_last      = (r_cnt == CNT_W'(NUM_PATTERNS - 1));
  assign w_seed_zero = (i_seed == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          // An all-zero seed would lock the LFSR; report it without running.
          w_state_next = w_seed_zero ? ST_DONE : ST_SEED;
        end
      end
      ST_SEED: w_state_next = i_abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (i_abort) begin
          w_state_next = ST_IDLE;
        end else if (w_last) begin
          w_state_next = ST_CMP;
        end
      end
      ST_CMP:  w_state_next = i_abort ? ST_IDLE : ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic; abort suppresses datapath activity in the same cycle.
  always_comb begin
    w_lfsr_rst  = 1'b0;
    w_lfsr_en   = 1'b0;
    w_bist_mode = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_misr_clr  = 1'b0;
    w_misr_en   = 1'b0;
    case (r_state)
      ST_SEED: begin
        w_busy      = 1'b1;
        w_lfsr_rst  = !i_abort;
        w_bist_mode = !i_abort;
        w_misr_clr  = 1'b1;
      end
      ST_RUN: begin
        w_busy      = 1'b1;
        w_bist_mode = !i_abort;
        w_misr_en   = !i_abort;
        // The last pattern is already on the LFSR; no further step needed.
        w_lfsr_en   = !i_abort && !w_last;
      end
      ST_CMP: begin
        w_busy = 1'b1;
      end
      ST_DONE: begin
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Pattern counter, captured configuration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_seed      <= '0;
      r_poly      <= '0;
      r_golden    <= '0;
      r_signature <= '0;
      r_pass      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_seed      <= i_seed;
        r_poly      <= i_poly;
        r_golden    <= i_golden_sig;
        r_signature <= '0;
        r_pass      <= 1'b0;
        r_err       <= w_seed_zero;
      end

      if (r_state == ST_SEED) begin
        r_cnt <= '0;
      end else if (r_state == ST_RUN && !i_abort && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_CMP && !i_abort) begin
        r_signature <= w_misr_sig;
        r_pass      <= (w_misr_sig == r_golden);
      end

      if (w_abort_act) begin
        r_pass <= 1'b0;
        r_err  <= 1'b0;
      end
    end
  end

  bist_misr #(
    .n         (n),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_misr_clr),
    .i_en   (w_misr_en),
    .i_resp (i_cut_resp),
    .o_sig  (w_misr_sig)
  );

  assign o_lfsr_rst  = w_lfsr_rst;
  assign o_lfsr_en   = w_lfsr_en;
  assign o_lfsr_seed = r_seed;
  assign o_lfsr_poly = r_poly;
  assign o_bist_mode = w_bist_mode;
  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_pass      = r_pass;
  assign o_err       = r_err;
  assign o_signature = r_signature;

endmodule

// File: tb/tb_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bist_ctrl
//   Drives directed sessions into bist_ctrl (NUM_PATTERNS=4), acts as the
//   parent's LFSR and a stand-in CUT, and checks every cycle against a
//   session-position model plus hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_bist_ctrl;

  localparam int         N  = 8;
  localparam int         NP = 4;
  localparam int         CW = 3;
  localparam logic [7:0] MP = 8'hB8;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] seed, poly, golden, cut_resp;
  logic       lfsr_rst, lfsr_en, bist_mode, busy, done, pass, err;
  logic [7:0] lfsr_seed, lfsr_poly, signature;

  always #5 clk = ~clk;

  bist_ctrl #(
    .n            (N),
    .NUM_PATTERNS (NP),
    .CNT_W        (CW),
    .MISR_POLY    (MP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_abort      (abort),
    .i_seed       (seed),
    .i_poly       (poly),
    .i_golden_sig (golden),
    .i_cut_resp   (cut_resp),
    .o_lfsr_rst   (lfsr_rst),
    .o_lfsr_en    (lfsr_en),
    .o_lfsr_seed  (lfsr_seed),
    .o_lfsr_poly  (lfsr_poly),
    .o_bist_mode  (bist_mode),
    .o_busy       (busy),
    .o_done       (done),
    .o_pass       (pass),
    .o_err        (err),
    .o_signature  (signature)
  );

  // One Galois right-shift step: shift down, fold the dropped bit back in
  // through the taps (the top tap is always present), then add the input word.
  function automatic logic [7:0] gstep(input logic [7:0] m, input logic [7:0] p,
                                       input logic [7:0] r);
    logic [7:0] fb;
    fb = m[0] ? {1'b1, p[6:0]} : 8'h00;
    return (m >> 1) ^ fb ^ r;
  endfunction

  // Parent-side LFSR and stand-in CUT
  logic [7:0] tb_lfsr = 8'h00;
  logic       resp_sel = 1'b0;
  logic [7:0] resp_const = 8'h00;

  always @(posedge clk) begin
    if (lfsr_rst)     tb_lfsr <= lfsr_seed;
    else if (lfsr_en) tb_lfsr <= gstep(tb_lfsr, lfsr_poly, 8'h00);
  end

  assign cut_resp = resp_sel ? (tb_lfsr ^ {tb_lfsr[3:0], tb_lfsr[7:4]} ^ 8'h5A) : resp_const;

  // Model: position within the session (0 = idle, 1 = cycle after start ...)
  int         m_pos  = 0;
  bit         m_zs   = 1'b0;
  logic [7:0] m_seed, m_poly, m_gold, m_misr, m_sig;
  logic       m_pass, m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_pos <= 0; m_zs <= 1'b0;
      m_seed <= 8'h00; m_poly <= 8'h00; m_gold <= 8'h00; m_misr <= 8'h00;
      m_sig <= 8'h00; m_pass <= 1'b0; m_err <= 1'b0;
    end else if (m_pos == 0) begin
      if (start && !abort) begin
        m_seed <= seed; m_poly <= poly; m_gold <= golden;
        m_pass <= 1'b0; m_sig <= 8'h00;
        m_err  <= (seed == 8'h00);
        m_zs   <= (seed == 8'h00);
        m_pos  <= 1;
      end
    end else if (m_zs || m_pos == NP + 3) begin
      m_pos <= 0;
    end else if (abort) begin
      m_pos <= 0; m_pass <= 1'b0; m_err <= 1'b0;
    end else begin
      if (m_pos == 1)            m_misr <= 8'h00;
      else if (m_pos <= NP + 1)  m_misr <= gstep(m_misr, MP, cut_resp);
      else begin
        m_sig  <= m_misr;
        m_pass <= (m_misr == m_gold);
      end
      m_pos <= m_pos + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  int done_cnt = 0, en_cnt = 0, lrst_cnt = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    logic e_rst, e_en, e_mode, e_busy, e_done;
    if (chk_on) begin
      e_rst  = !m_zs && m_pos == 1 && !abort;
      e_mode = !m_zs && m_pos >= 1 && m_pos <= NP + 1 && !abort;
      e_en   = !m_zs && m_pos >= 2 && m_pos <= NP && !abort;
      e_busy = !m_zs && m_pos >= 1 && m_pos <= NP + 2;
      e_done = m_zs ? (m_pos == 1) : (m_pos == NP + 3);
      chk("lfsr_rst",  {7'd0, lfsr_rst},  {7'd0, e_rst});
      chk("lfsr_en",   {7'd0, lfsr_en},   {7'd0, e_en});
      chk("bist_mode", {7'd0, bist_mode}, {7'd0, e_mode});
      chk("busy",      {7'd0, busy},      {7'd0, e_busy});
      chk("done",      {7'd0, done},      {7'd0, e_done});
      chk("pass",      {7'd0, pass},      {7'd0, m_pass});
      chk("err",       {7'd0, err},       {7'd0, m_err});
      chk("signature", signature, m_sig);
      chk("lfsr_seed", lfsr_seed, m_seed);
      chk("lfsr_poly", lfsr_poly, m_poly);
    end
    if (done)     done_cnt++;
    if (lfsr_en)  en_cnt++;
    if (lfsr_rst) lrst_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle and return the number of cycles until done.
  task automatic run_session(input string tag, output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 50) begin
      tick();
      lat++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, lat);
    end
    $display("session %s: latency=%0d pass=%0b err=%0b signature=%h", tag, lat, pass, err, signature);
    tick();
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int lat, d0;
    logic [7:0] ref_sig;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    seed = 8'h00; poly = 8'h00; golden = 8'h00;
    tick();
    chk_on = 1'b1;
    tick();
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_sig",  signature, 8'h00);
    chk("reset_seed", lfsr_seed, 8'h00);
    rst = 1'b0;
    tick();

    // T1: zero responses, zero golden
    seed = 8'h01; poly = 8'hB8; golden = 8'h00; resp_const = 8'h00; resp_sel = 1'b0;
    en_cnt = 0;
    run_session("T1", lat);
    chk("T1_latency", 8'(lat), 8'd7);
    chk("T1_pass", {7'd0, pass}, 8'h01);
    chk("T1_sig", signature, 8'h00);
    chk("T1_en_cycles", 8'(en_cnt), 8'd3);

    // T2: constant response 01 -> 00,01,B9,E5,CB after four absorptions
    resp_const = 8'h01;
    run_session("T2", lat);
    chk("T2_pass", {7'd0, pass}, 8'h00);
    chk("T2_sig", signature, 8'hCB);

    // T3: zero seed is rejected without touching the LFSR
    seed = 8'h00;
    lrst_cnt = 0;
    run_session("T3", lat);
    chk("T3_latency", 8'(lat), 8'd1);
    chk("T3_lfsr_rst", 8'(lrst_cnt), 8'd0);
    chk("T3_err", {7'd0, err}, 8'h01);
    chk("T3_pass", {7'd0, pass}, 8'h00);

    // Reference session with real LFSR-driven responses
    seed = 8'h3C; poly = 8'hB8; golden = 8'h00; resp_sel = 1'b1;
    run_session("REF", lat);
    ref_sig = signature;
    golden = ref_sig;
    run_session("REF_GOLD", lat);
    chk("REF_pass", {7'd0, pass}, 8'h01);

    // T4: abort in RUN cycle 2
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;   // SEED
    tick(); tick(); tick();               // RUN0, RUN1, RUN2
    abort = 1'b1; tick(); abort = 1'b0;
    chk("T4_busy_after_abort", {7'd0, busy}, 8'h00);
    tick(); tick();
    chk("T4_no_done", 8'(done_cnt - d0), 8'd0);
    $display("session T4a: aborted in RUN cycle 2");
    run_session("T4b", lat);
    chk("T4_sig", signature, ref_sig);
    chk("T4_pass", {7'd0, pass}, 8'h01);

    // T5: extra start during RUN is ignored
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;   // SEED
    tick(); tick();                       // RUN1
    start = 1'b1; tick(); start = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin tick(); lat++; end
    tick(); tick(); tick();
    chk("T5_one_done", 8'(done_cnt - d0), 8'd1);
    chk("T5_sig", signature, ref_sig);
    $display("session T5: done_pulses=%0d signature=%h", done_cnt - d0, signature);

    // T6: reset in RUN cycle 1, then start+abort together in IDLE
    start = 1'b1; tick(); start = 1'b0;   // SEED
    tick(); tick();                       // RUN1
    rst = 1'b1; tick(); rst = 1'b0;
    chk("T6_busy", {7'd0, busy}, 8'h00);
    chk("T6_mode", {7'd0, bist_mode}, 8'h00);
    chk("T6_pass", {7'd0, pass}, 8'h00);
    chk("T6_sig", signature, 8'h00);
    chk("T6_seed", lfsr_seed, 8'h00);
    d0 = done_cnt;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("T6_idle_busy", {7'd0, busy}, 8'h00);
    tick(); tick();
    chk("T6_no_done", 8'(done_cnt - d0), 8'd0);
    $display("session T6: reset mid-run and start+abort in idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
